// File: rtl/riscv_bus_pkg.sv
// Shared bus definitions for the data-memory path.
// FSM encoding, bus widths and address helpers.
package riscv_bus_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } rsp_state_e;

  function automatic logic word_aligned(
    input logic [XLEN-1:0] addr
  );
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data RAM with byte-enable write
// and registered read.
module dmem_array
  import riscv_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [BE_W-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store bus target: one request at a time,
// fixed wait states, then a held response.
module dmem_responder
  import riscv_bus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [XLEN-1:0] SPAN =
    XLEN'(DEPTH_WORDS * 4);

  rsp_state_e      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;

  logic [XLEN-1:0] off;
  logic            fault;
  logic            accept;
  logic            ram_we;
  logic            ram_re;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_rdata;

  // Below-base addresses wrap high and fail the range test.
  assign off    = req_addr - BASE_ADDR;
  assign fault  = !word_aligned(req_addr) || (off >= SPAN);
  assign accept = req_valid && req_ready;
  assign ram_we = accept && req_we && !fault;

  assign ram_addr = (state_q == ST_IDLE) ? off[AW+1:2] : idx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ram_re  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            ram_re  = !req_we && !fault;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          ram_re  = !we_q && !err_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= req_we;
        err_q <= fault;
        idx_q <= off[AW+1:2];
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .be_i   (req_be),
    .addr_i (ram_addr),
    .wdata_i(req_wdata),
    .rdata_o(ram_rdata)
  );

  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata =
    (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a
// word-array memory model.
module tb_dmem_responder;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0, r0, we0, rv0, rr0, re0;
  logic [31:0] a0, wd0, rd0;
  logic [3:0]  be0;

  logic [31:0] mem_m [1024];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(WAITC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(v0),
    .req_ready(r0),
    .req_we   (we0),
    .req_addr (a0),
    .req_wdata(wd0),
    .req_be   (be0),
    .rsp_valid(rv0),
    .rsp_ready(rr0),
    .rsp_rdata(rd0),
    .rsp_err  (re0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic        we,
                     input logic [31:0] a,
                     input logic [31:0] wd,
                     input logic [3:0]  be,
                     input int          hold);
    logic        ee;
    logic [31:0] er;
    int          n;
    int          lat;
    ee = (a[1:0] != 2'b00) || (a >= 32'h1000);
    er = 32'h0;
    if (!ee && we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem_m[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    end
    if (!ee && !we) er = mem_m[a[11:2]];
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, WAITC + 1);
    for (int i = 0; i < hold; i++) begin
      chk("bp_rdata", rsp_rdata, er);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    chk("rdata", rsp_rdata, er);
    chk("err", rsp_err, ee);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after", req_ready, 1);
    chk("valid_after", rsp_valid, 0);
  endtask

  initial begin
    int k;
    logic [31:0] a;
    rst_n = 1'b0;
    req_valid = 0; req_we = 0; req_addr = 0;
    req_wdata = 0; req_be = 0; rsp_ready = 0;
    v0 = 0; we0 = 0; a0 = 0; wd0 = 0; be0 = 0; rr0 = 1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_err", rsp_err, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_ready", req_ready, 1);
    chk("rel_ready0", r0, 1);

    // Zero-wait instance, request held with rsp_ready high.
    @(negedge clk);
    v0 = 1; we0 = 1; a0 = 0; wd0 = 32'hA5A5_0000; be0 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      chk("w0_ready", r0, 32'((i % 2) == 0));
      chk("w0_valid", rv0, 32'((i % 2) == 1));
      @(negedge clk);
    end
    chk("w0_ready_end", r0, 1);
    we0 = 0;
    @(negedge clk);
    chk("w0_ld_valid", rv0, 1);
    chk("w0_ld_rdata", rd0, 32'hA5A5_0000);
    chk("w0_ld_err", re0, 0);
    v0 = 0;

    txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 32'h10, 32'h0, 4'h0, 0);
    chk("ld_0x10", mem_m[4], 32'hDEADBEEF);
    txn(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1, 32'h20, 32'h1122_3344, 4'b0101, 0);
    txn(0, 32'h20, 32'h0, 4'h0, 0);
    chk("be_model", mem_m[8], 32'hFF22_FF44);
    txn(0, 32'h22, 32'h0, 4'hF, 0);
    txn(1, 32'h0, 32'h1357_9BDF, 4'hF, 0);
    txn(1, 32'h1000, 32'hBAD0_BAD0, 4'hF, 0);
    txn(0, 32'h0, 32'h0, 4'hF, 0);
    txn(1, 32'h30, 32'h0BAD_F00D, 4'h0, 0);
    txn(1, 32'hFFFF_FFFC, 32'h0, 4'hF, 0);
    txn(0, 32'h10, 32'h0, 4'hF, 7);

    for (int w = 0; w < 64; w++)
      txn(1, 32'(w * 4), $urandom, 4'hF, 0);

    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 63)) << 2;
      if (k == 0) a = a | 32'($urandom_range(1, 3));
      else if (k == 1) a = 32'h1000 + a;
      else if (k == 2) a = 32'hFFFF_FF00 + a;
      txn(1'($urandom_range(0, 1)), a, $urandom,
          4'($urandom), $urandom_range(0, 2));
    end

    // Reset during the wait of an accepted store.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h44;
    req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    mem_m[17] = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    txn(0, 32'h44, 32'h0, 4'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-mapped data-memory responder for the RISC-V core: the target end of the core's load/store bus. It accepts one request at a time over a valid/ready request channel, inserts a programmable number of wait states, and returns read data, write acknowledgement or an error over a valid/ready response channel. The system top instantiates it between the core's LSU port and the word-addressed data RAM.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between request acceptance and response; range 0–15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access fault.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata/be and evaluate the fault. Go to WAIT with the counter loaded to WAIT_CYCLES-1, or go straight to RESP if WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle. At 0, go to RESP.
- RESP: rsp_valid=1. All rsp_* outputs are held stable until rsp_ready. On rsp_valid&&rsp_ready, return to IDLE.
- Fault: addr[1:0]≠0, or addr outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
  - The result is rsp_err=1 and rsp_rdata=0. A faulting store has no RAM effect.
- Store without fault:
  - Write the enabled bytes at word index (addr-BASE_ADDR)>>2, on the acceptance edge.
  - be=0 is legal: nothing is written, and rsp_err=0.
- Load without fault:
  - RAM is read on the edge entering RESP; rsp_rdata is registered on that edge.
  - req_be is ignored; the full word is returned.
- Store response: rsp_rdata=0, rsp_err=0.
- req_* inputs are ignored outside IDLE; a request held valid is accepted only when the FSM is back in IDLE.
- RAM contents are not reset and are X until written.

## Timing
- Reset values: req_ready=0 while rst_n=0, and 1 in the first cycle after release. rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
- Latency: rsp_valid rises WAIT_CYCLES+1 cycles after the acceptance edge.
- There is no bypass: req_ready rises the cycle after the response handshake. Peak throughput is one transaction per WAIT_CYCLES+2 cycles.
- Read-after-write: a load accepted after a store's response returns the stored bytes.
- rsp_ready may be high before rsp_valid; the handshake then completes on the first RESP cycle.
- Reset mid-transaction (WAIT or RESP):
  - The transaction is abandoned and outputs return to reset values immediately.
  - A store already committed at acceptance stays in RAM.
- Address arithmetic: the 32-bit subtraction addr-BASE_ADDR is used for the range check. Addresses below BASE_ADDR wrap to large values and therefore fault.

## Structure
- Shared package riscv_bus_pkg:
  - FSM state enum;
  - bus width constants XLEN=32 and BE_W=4;
  - the alignment-check function.
- Sub-module dmem_array: single-port synchronous RAM with byte-enable write and registered read, parameterised by DEPTH_WORDS. Maps to BRAM.
- The FSM, wait counter and fault logic live in dmem_responder.

## Test plan
- Reset: hold rst_n=0 for 5 cycles -> req_ready=0 and rsp_valid=0 throughout; req_ready=1 the cycle after release.
- Store then load, WAIT_CYCLES=2:
  - store addr 0x10, wdata 0xDEADBEEF, be=4'hF -> rsp_valid high 3 cycles after acceptance, err=0;
  - load 0x10 -> rdata 0xDEADBEEF.
- Byte enables: store 0x11223344 at 0x20 with be=4'b0101 over prior 0xFFFFFFFF -> load 0x20 returns 0xFF22FF44.
- Faults:
  - load 0x22 (misaligned) -> err=1, rdata=0;
  - store 0x1000 with DEPTH_WORDS=1024 -> err=1 and RAM unchanged.
- Response backpressure: hold rsp_ready=0 for 7 cycles -> rsp_valid/rdata stable, req_ready=0; the handshake on cycle 8 gives req_ready=1 the next cycle.
- WAIT_CYCLES=0: back-to-back requests -> rsp_valid 1 cycle after acceptance; a new acceptance every 2 cycles with rsp_ready tied high.
- Mid-wait reset: assert rst_n during WAIT -> rsp_valid never rises; after release, a load of the previously stored word returns its data.
